muldiv_unit: RTL and testbench

Iterative unsigned multiply/divide unit. It sits downstream of the control/ALU decoder and consumes alu_ctrl_t codes MULTUac, DIVUac, MFHIac and MFLOac. It owns the architectural HI/LO registers and runs MULTU/DIVU over WIDTH cycles. While an operation is in flight it returns a stall so the pipeline holds any dependent HI/LO access.

---
 rtl/muldiv_unit_pkg.sv | 41 ++++
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_unit_divu_step.sv | 28 ++
 rtl/muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   alu_ctrl_t     : decoder control codes (only MULTU/DIVU/MFHI/MFLO matter here)
//   muldiv_state_t : sequencer states
//   MULDIV_ITERS   : default operand width, which is also the iteration count
package muldiv_unit_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [3:0] {
    DONT_CAREac = 4'h0,
    ADDac       = 4'h1,
    SUBac       = 4'h2,
    ANDac       = 4'h3,
    ORac        = 4'h4,
    XORac       = 4'h5,
    SLTac       = 4'h6,
    SLLac       = 4'h7,
    MULTUac     = 4'h8,
    DIVUac      = 4'h9,
    MFHIac      = 4'hA,
    MFLOac      = 4'hB
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } muldiv_state_t;

  // Codes that launch an iterative operation.
  function automatic logic is_start_op(alu_ctrl_t op);
    return (op == MULTUac) || (op == DIVUac);
  endfunction

  // Codes that depend on HI/LO and therefore must wait while busy.
  function automatic logic is_hilo_op(alu_ctrl_t op);
    return (op == MULTUac) || (op == DIVUac) || (op == MFHIac) || (op == MFLOac);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Decoder <-> multiply/divide unit connection.
//   master : decoder side, drives alu_ctrl/a/b and observes status and HI/LO
//   slave  : muldiv_unit side
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_ITERS
);

  alu_ctrl_t         alu_ctrl;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic              stall;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  result;
  logic              div_by_zero;

  modport master (
    output alu_ctrl, a, b,
    input  busy, done, stall, hi, lo, result, div_by_zero
  );

  modport slave (
    input  alu_ctrl, a, b,
    output busy, done, stall, hi, lo, result, div_by_zero
  );

endinterface

// File: rtl/muldiv_unit_divu_step.sv
// One restoring-division iteration (combinational).
//   r_in/q_in : partial remainder (WIDTH+1 bits) and quotient/dividend shift register
//   divisor   : divisor
//   r_out/q_out : values after shifting {R,Q} left and trying a subtract
module muldiv_unit_divu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    // Keep the full shifted remainder so the compare never loses a bit.
    shifted = {r_in, q_in[WIDTH-1]};
    fits    = shifted >= {2'b00, divisor};
    trial   = shifted - {2'b00, divisor};
    r_out   = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
    q_out   = {q_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit owning the architectural HI/LO registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of muldiv_unit_if (alu_ctrl/a/b in; busy, done, stall,
//              hi, lo, result, div_by_zero out)
// An operation takes WIDTH step cycles plus one FINISH cycle that writes HI/LO;
// done pulses in the following (idle) cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_ITERS
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned AccW = 2 * WIDTH + 1;
  localparam logic [CntW-1:0] IterCnt = CntW'(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(1);

  muldiv_state_t     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Shared datapath: MUL uses {carry, P_hi, P_lo}, DIV uses {R, Q}.
  logic [AccW-1:0]   acc_q, acc_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              dbz_q, dbz_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    mul_sum;
  logic [AccW-1:0]   mul_acc;
  logic [AccW-1:0]   mul_next;
  logic [WIDTH:0]    div_r_next;
  logic [WIDTH-1:0]  div_q_next;
  logic              start;
  logic              start_div;

  muldiv_unit_divu_step #(
    .WIDTH (WIDTH)
  ) u_divu_step (
    .r_in    (acc_q[AccW-1:WIDTH]),
    .q_in    (acc_q[WIDTH-1:0]),
    .divisor (opnd_q),
    .r_out   (div_r_next),
    .q_out   (div_q_next)
  );

  // Shift-add multiply step: add multiplicand into the upper half when P_lo[0]
  // is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AccW-2:WIDTH]} + {1'b0, opnd_q};
    mul_acc  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:0]} : acc_q;
    mul_next = mul_acc >> 1;
  end

  always_comb begin
    start     = (state_q == IDLE) && is_start_op(bus.alu_ctrl);
    start_div = bus.alu_ctrl == DIVUac;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = IterCnt;
          if (start_div) begin
            state_d = DIV;
            opnd_d  = bus.b;
            acc_d   = {{(WIDTH + 1){1'b0}}, bus.a};
            dbz_d   = bus.b == '0;
          end else begin
            state_d = MUL;
            opnd_d  = bus.a;
            acc_d   = {{(WIDTH + 1){1'b0}}, bus.b};
            dbz_d   = 1'b0;
          end
        end
      end
      MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - LastCnt;
        if (cnt_q == LastCnt) state_d = FINISH;
      end
      DIV: begin
        acc_d = {div_r_next, div_q_next};
        cnt_d = cnt_q - LastCnt;
        if (cnt_q == LastCnt) state_d = FINISH;
      end
      FINISH: begin
        // Both algorithms leave the HI result in bits [2W-1:W] and LO in [W-1:0].
        hi_d    = acc_q[AccW-2:WIDTH];
        lo_d    = acc_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.busy        = state_q != IDLE;
    bus.done        = done_q;
    bus.stall       = (state_q != IDLE) && is_hilo_op(bus.alu_ctrl);
    bus.hi          = hi_q;
    bus.lo          = lo_q;
    bus.div_by_zero = dbz_q;
    case (bus.alu_ctrl)
      MFHIac:  bus.result = hi_q;
      MFLOac:  bus.result = lo_q;
      default: bus.result = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: fixed-latency MULTU/DIVU runs, stalls,
// ignored starts while busy, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] mdl_hi = '0;
  logic [W-1:0] mdl_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic hazard(input alu_ctrl_t op);
    return op == MULTUac || op == DIVUac || op == MFHIac || op == MFLOac;
  endfunction

  function automatic logic [W-1:0] exp_result(input alu_ctrl_t op);
    if (op == MFHIac) return mdl_hi;
    if (op == MFLOac) return mdl_lo;
    return '0;
  endfunction

  // Issue op at cycle 0 (unit must be idle), hold `hold` in cycles 1..33 except
  // cycle inj where an extra DIVU is presented; returns in cycle 34 (done cycle).
  task automatic run(input string tag, input alu_ctrl_t op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input alu_ctrl_t hold, input int inj,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    bus.alu_ctrl = op;
    bus.a = a;
    bus.b = b;
    tick();
    chk({tag, "_dbz_latched"}, 64'(bus.div_by_zero), 64'(edbz));
    for (int c = 1; c <= 33; c++) begin
      bus.alu_ctrl = (c == inj) ? DIVUac : hold;
      if (c == inj) begin
        bus.a = 32'd999;
        bus.b = 32'd1;
      end
      #1;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, "_nodone"}, 64'(bus.done), 64'd0);
      chk({tag, "_stall"}, 64'(bus.stall), 64'(hazard(bus.alu_ctrl)));
      chk({tag, "_hi_hold"}, 64'(bus.hi), 64'(mdl_hi));
      chk({tag, "_lo_hold"}, 64'(bus.lo), 64'(mdl_lo));
      tick();
    end
    mdl_hi = ehi;
    mdl_lo = elo;
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    chk({tag, "_stall_end"}, 64'(bus.stall), 64'd0);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({tag, "_result"}, 64'(bus.result), 64'(exp_result(bus.alu_ctrl)));
  endtask

  initial begin
    bus.alu_ctrl = DONT_CAREac;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    tick();
    chk("idle_nostart", 64'(bus.busy), 64'd0);

    // 1, 2: multiplies.
    run("mul_3x5", MULTUac, 32'd3, 32'd5, DONT_CAREac, 0, 32'h0, 32'hF, 1'b0);
    bus.alu_ctrl = DONT_CAREac;
    tick();
    chk("mul_done_one_cycle", 64'(bus.done), 64'd0);
    run("mul_max", MULTUac, 32'hFFFF_FFFF, 32'hFFFF_FFFF, DONT_CAREac, 0,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    bus.alu_ctrl = DONT_CAREac;
    tick();

    // 3: divides, including divide by zero and its sticky flag.
    run("div_100_7", DIVUac, 32'd100, 32'd7, DONT_CAREac, 0, 32'd2, 32'd14, 1'b0);
    bus.alu_ctrl = DONT_CAREac;
    tick();
    run("div_by0", DIVUac, 32'h1234_5678, 32'd0, DONT_CAREac, 0,
        32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    bus.alu_ctrl = DONT_CAREac;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dbz_sticky", 64'(bus.div_by_zero), 64'd1);
    end
    bus.alu_ctrl = MFHIac;
    #1;
    chk("mfhi_idle", 64'(bus.result), 64'h1234_5678);
    chk("mfhi_no_stall", 64'(bus.stall), 64'd0);
    bus.alu_ctrl = DONT_CAREac;
    tick();

    // 4: MFLO held during a multiply, ignored DIVU at cycle 10.
    run("mul_6x7_mflo", MULTUac, 32'd6, 32'd7, MFLOac, 10, 32'd0, 32'd42, 1'b0);
    chk("mflo_result_42", 64'(bus.result), 64'd42);
    bus.alu_ctrl = DONT_CAREac;
    tick();
    chk("inj_not_started", 64'(bus.busy), 64'd0);
    chk("inj_lo_kept", 64'(bus.lo), 64'd42);

    // 5: DIVU issued in the MULTU done cycle.
    run("b2b_mul", MULTUac, 32'h0001_0000, 32'h0003_0000, DONT_CAREac, 0,
        32'd3, 32'd0, 1'b0);
    run("b2b_div", DIVUac, 32'd50, 32'd8, DONT_CAREac, 0, 32'd2, 32'd6, 1'b0);
    bus.alu_ctrl = DONT_CAREac;
    tick();

    // 6: reset in cycle 10 of a divide.
    bus.alu_ctrl = DIVUac;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    tick();
    bus.alu_ctrl = DONT_CAREac;
    for (int c = 1; c < 10; c++) tick();
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_hi = '0;
    mdl_lo = '0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    for (int i = 0; i < 40; i++) begin
      chk("abort_no_done", 64'(bus.done), 64'd0);
      tick();
    end
    run("mul_2x2", MULTUac, 32'd2, 32'd2, DONT_CAREac, 0, 32'd0, 32'd4, 1'b0);
    bus.alu_ctrl = DONT_CAREac;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
